// File: rtl/paddle_position_ctrl.sv
// Vertical position controller for one paddle: per-frame moves with clamping to the playfield.
// Optional speed ramp while a direction is held is enabled by defining PADDLE_ACCEL_EN.
module paddle_position_ctrl #(
    parameter int TOP_BOUND    = 165,
    parameter int BOT_BOUND    = 434,
    parameter int PADDLE_H     = 60,
    parameter int RESET_TOP    = 270,
    parameter int STEP         = 4,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        move_up,
    input  logic        move_down,
    output logic [10:0] P_upper_limit,
    output logic [10:0] P_down_limit,
    output logic        at_top,
    output logic        at_bottom,
    output logic        moving,
    output logic [3:0]  speed,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    localparam logic [11:0] TOP12       = 12'(TOP_BOUND);
    localparam logic [11:0] UPPER_MAX12 = 12'(BOT_BOUND - PADDLE_H);
    localparam logic [10:0] TOP11       = 11'(TOP_BOUND);
    localparam logic [10:0] BOT11       = 11'(BOT_BOUND);
    localparam logic [10:0] PH11        = 11'(PADDLE_H);
    localparam logic [10:0] RESET_TOP11 = 11'(RESET_TOP);
    localparam logic [10:0] RESET_DN11  = 11'(RESET_TOP + PADDLE_H);
    // The speed never exceeds the ceiling, even if STEP is configured above it.
    localparam logic [3:0]  MAX4        = 4'(MAX_SPEED);
    localparam logic [3:0]  BASE_SPEED  = (STEP > MAX_SPEED) ? MAX4 : 4'(STEP);

    logic [1:0]  state_q, state_d;
    logic [10:0] upper_q, upper_d;
    logic [10:0] down_q, down_d;
    logic        at_top_q, at_top_d;
    logic        at_bottom_q, at_bottom_d;
    logic [3:0]  speed_q, speed_d;

    logic [1:0]  dir_next;
    logic [3:0]  speed_eff;
    logic [11:0] upper_ext;
    logic [11:0] spd_ext;
    logic [11:0] diff_ext;
    logic [11:0] sum_ext;

`ifdef PADDLE_ACCEL_EN
    localparam logic [7:0] ACC8 = 8'(ACCEL_FRAMES);

    logic [7:0] accel_cnt_q, accel_cnt_d;
    logic [3:0] run_speed_q, run_speed_d;
    logic [7:0] cnt_inc;
    logic       same_dir;
`else
    logic cfg_unused;
    assign cfg_unused = ^{32'(ACCEL_FRAMES), 32'(MAX_SPEED)};
`endif

    // Direction requested this frame; conflicting requests mean no motion.
    always_comb begin
        dir_next = ST_IDLE;
        if (move_up && !move_down) begin
            dir_next = ST_UP;
        end else if (move_down && !move_up) begin
            dir_next = ST_DOWN;
        end
    end

`ifdef PADDLE_ACCEL_EN
    always_comb begin
        same_dir  = (dir_next == state_q) && (dir_next != ST_IDLE);
        speed_eff = same_dir ? run_speed_q : BASE_SPEED;
    end
`else
    assign speed_eff = BASE_SPEED;
`endif

    always_comb begin
        state_d     = state_q;
        upper_d     = upper_q;
        speed_d     = speed_q;
        upper_ext   = {1'b0, upper_q};
        spd_ext     = {8'd0, speed_eff};
        diff_ext    = upper_ext - spd_ext;
        sum_ext     = upper_ext + spd_ext;

        if (frame_tick) begin
            state_d = dir_next;
            speed_d = speed_eff;
            case (dir_next)
                ST_UP: begin
                    // Compare before subtracting so the result never wraps below the bound.
                    if (upper_ext < TOP12 + spd_ext) begin
                        upper_d = TOP11;
                    end else begin
                        upper_d = diff_ext[10:0];
                    end
                end
                ST_DOWN: begin
                    if (sum_ext > UPPER_MAX12) begin
                        upper_d = UPPER_MAX12[10:0];
                    end else begin
                        upper_d = sum_ext[10:0];
                    end
                end
                default: upper_d = upper_q;
            endcase
        end

        down_d      = upper_d + PH11;
        at_top_d    = (upper_d == TOP11);
        at_bottom_d = (down_d == BOT11);
    end

`ifdef PADDLE_ACCEL_EN
    // The entry tick counts as the first frame of a run; a bumped speed applies from the next tick.
    always_comb begin
        accel_cnt_d = accel_cnt_q;
        run_speed_d = run_speed_q;
        cnt_inc     = same_dir ? (accel_cnt_q + 8'd1) : 8'd1;
        if (frame_tick) begin
            if (dir_next == ST_IDLE) begin
                accel_cnt_d = 8'd0;
                run_speed_d = BASE_SPEED;
            end else if (cnt_inc >= ACC8) begin
                accel_cnt_d = 8'd0;
                run_speed_d = (speed_eff >= MAX4) ? MAX4 : (speed_eff + 4'd1);
            end else begin
                accel_cnt_d = cnt_inc;
                run_speed_d = speed_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            accel_cnt_q <= 8'd0;
            run_speed_q <= BASE_SPEED;
        end else begin
            accel_cnt_q <= accel_cnt_d;
            run_speed_q <= run_speed_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            upper_q     <= RESET_TOP11;
            down_q      <= RESET_DN11;
            at_top_q    <= (RESET_TOP11 == TOP11);
            at_bottom_q <= (RESET_DN11 == BOT11);
            speed_q     <= BASE_SPEED;
        end else begin
            state_q     <= state_d;
            upper_q     <= upper_d;
            down_q      <= down_d;
            at_top_q    <= at_top_d;
            at_bottom_q <= at_bottom_d;
            speed_q     <= speed_d;
        end
    end

    assign P_upper_limit = upper_q;
    assign P_down_limit  = down_q;
    assign at_top        = at_top_q;
    assign at_bottom     = at_bottom_q;
    assign moving        = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign speed         = speed_q;
    assign fsm_state     = state_q;

endmodule
